// File: rtl/ddr_sync_dc_tx_arbiter_pkg.sv
// ddr_sync_pkg: shared slot-state and owner types for the DDR sync tx arbiter
package ddr_sync_pkg;
  typedef enum logic {SLOT_U, SLOT_L} slot_state_e;
  typedef logic owner_t;
  localparam owner_t OWNER_REQ0 = 1'b0;
  localparam owner_t OWNER_REQ1 = 1'b1;
endpackage

// File: rtl/ddr_sync_dc_tx_arbiter_if.sv
// ddr_sync_dc_tx_arbiter_if: one full-width word requester (valid/data/last in, ready back)
interface ddr_sync_dc_tx_arbiter_if #(parameter int W = 32);
  logic         valid;
  logic [W-1:0] data;
  logic         last;
  logic         ready;
  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/ddr_sync_dc_tx_arbiter_rr_arb2_lock.sv
// rr_arb2_lock: 2-way round-robin arbiter that locks onto a requester until its last word
module rr_arb2_lock
  import ddr_sync_pkg::*;
(
  input  logic       local_clk,
  input  logic       reset_n,
  input  logic       take,
  input  logic       en,
  input  logic [1:0] valid,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output owner_t     sel,
  output logic       acc,
  output logic       busy
);
  owner_t ptr, owner;
  // each grant bit looks only at the other requester's valid, so ready never loops back on itself
  always_comb begin
    gnt = !take ? 2'b00 : busy ? (owner ? 2'b10 : 2'b01) : en ? {ptr | ~valid[0], ~ptr | ~valid[1]} : 2'b00;
    sel = owner_t'(gnt[1] & valid[1]);
    acc = |(gnt & valid);
  end
  always_ff @(posedge local_clk or negedge reset_n)
    if (!reset_n) begin
      ptr   <= OWNER_REQ0;
      owner <= OWNER_REQ0;
      busy  <= 1'b0;
    end else if (acc) begin
      busy  <= !last[sel];
      owner <= sel;
      if (last[sel]) ptr <= ~sel;
    end
endmodule

// File: rtl/ddr_sync_dc_tx_arbiter.sv
// ddr_sync_dc_tx_arbiter: shares a 2x-clock half-width datapath between two word requesters
module ddr_sync_dc_tx_arbiter
  import ddr_sync_pkg::*;
#(
  parameter int                   SRC_WIDTH = 32,
  parameter int                   DST_WIDTH = SRC_WIDTH / 2,
  parameter bit                   PHASE     = 1'b0,
  parameter logic [SRC_WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                     local_clk,
  input  logic                     reset_n,
  input  logic                     phase_in,
  input  logic                     en,
  ddr_sync_dc_tx_arbiter_if.slave  req0,
  ddr_sync_dc_tx_arbiter_if.slave  req1,
  output logic [DST_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  output owner_t                   out_owner,
  output logic                     busy,
  output logic                     phase_err
);
  if (SRC_WIDTH % 2 != 0 || DST_WIDTH * 2 != SRC_WIDTH) begin : g_bad_width
    $error("SRC_WIDTH must be even and DST_WIDTH half of it");
  end
  localparam logic [DST_WIDTH-1:0] IDLE_U = IDLE_WORD[SRC_WIDTH-1:DST_WIDTH];
  localparam logic [DST_WIDTH-1:0] IDLE_L = IDLE_WORD[DST_WIDTH-1:0];
  slot_state_e          state, state_nx;
  logic                 upper, take, acc;
  logic [1:0]           gnt;
  owner_t               sel;
  logic [SRC_WIDTH-1:0] sel_data;
  logic [DST_WIDTH-1:0] hold;
  assign upper     = phase_in ^ PHASE;
  assign take      = upper && state == SLOT_U;
  assign req0.ready = gnt[0];
  assign req1.ready = gnt[1];
  assign sel_data  = sel ? req1.data : req0.data;
  rr_arb2_lock u_arb (
    .local_clk (local_clk),
    .reset_n   (reset_n),
    .take      (take),
    .en        (en),
    .valid     ({req1.valid, req0.valid}),
    .last      ({req1.last, req0.last}),
    .gnt       (gnt),
    .sel       (sel),
    .acc       (acc),
    .busy      (busy)
  );
  always_comb begin
    state_nx = SLOT_U;
    if (state == SLOT_U && upper) state_nx = SLOT_L;
  end
  // an idle upper slot loads the idle lower half into hold, so SLOT_L always just drains hold
  always_ff @(posedge local_clk or negedge reset_n)
    if (!reset_n) begin
      state     <= SLOT_U;
      out_data  <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_owner <= OWNER_REQ0;
      phase_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == SLOT_L) begin
        out_data <= hold;
        if (upper) phase_err <= 1'b1;
      end else if (!upper) begin
        out_data  <= IDLE_L;
        out_valid <= 1'b0;
        phase_err <= 1'b1;
      end else if (acc) begin
        out_data  <= sel_data[SRC_WIDTH-1:DST_WIDTH];
        hold      <= sel_data[DST_WIDTH-1:0];
        out_valid <= 1'b1;
        out_owner <= sel;
      end else begin
        out_data  <= IDLE_U;
        hold      <= IDLE_L;
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_ddr_sync_dc_tx_arbiter.sv
// tb_ddr_sync_dc_tx_arbiter: scoreboard bench with a slot-level reference model
module tb_ddr_sync_dc_tx_arbiter;
  import ddr_sync_pkg::*;
  localparam int          SW   = 32;
  localparam int          DW   = 16;
  localparam bit          PH   = 1'b1;
  localparam logic [31:0] IDLE = 32'hDEAD_BEEF;

  logic local_clk = 1'b0, reset_n = 1'b1, phase_in = 1'b0, en = 1'b1;
  logic [DW-1:0] out_data;
  logic out_valid, busy, phase_err;
  owner_t out_owner;

  ddr_sync_dc_tx_arbiter_if #(.W(SW)) req0 ();
  ddr_sync_dc_tx_arbiter_if #(.W(SW)) req1 ();

  ddr_sync_dc_tx_arbiter #(.SRC_WIDTH(SW), .DST_WIDTH(DW), .PHASE(PH), .IDLE_WORD(IDLE)) dut (
    .local_clk (local_clk),
    .reset_n   (reset_n),
    .phase_in  (phase_in),
    .en        (en),
    .req0      (req0),
    .req1      (req1),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_owner (out_owner),
    .busy      (busy),
    .phase_err (phase_err)
  );

  always #5 local_clk = ~local_clk;

  typedef struct {logic [31:0] d; bit last; int gap;} word_t;
  word_t src0[$], src1[$];
  logic [15:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  bit mon_on = 0, up = 0, stick = 0, en_rand = 0;
  // reference model: slot position, rr favourite, packet lock, expected outputs
  bit m_l, m_ptr, m_lock, m_lock_own, m_err, m_outv, m_oown;
  logic [15:0] m_idle;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_l = 0; m_ptr = 0; m_lock = 0; m_lock_own = 0; m_err = 0; m_outv = 0; m_oown = 0; m_idle = '0;
  endtask

  always @(negedge local_clk) begin
    logic [15:0] e;
    if (mon_on && reset_n) begin
      chk("out_valid", out_valid, m_outv);
      chk("phase_err", phase_err, m_err);
      chk("busy", busy, m_lock);
      chk("out_owner", out_owner, m_oown);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word: got %h, expected no word at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", out_data, e);
        end
      end else chk("idle_data", out_data, m_idle);
    end
  end

  task automatic cyc();
    bit v0, v1;
    int w;
    word_t x;
    @(negedge local_clk);
    if (stick) stick = 0; else up = ~up;
    phase_in = up ^ PH;
    if (en_rand) en = $urandom_range(0, 9) < 7;
    v0 = src0.size() > 0 && src0[0].gap == 0;
    v1 = src1.size() > 0 && src1[0].gap == 0;
    if (src0.size() > 0 && src0[0].gap > 0) src0[0].gap = src0[0].gap - 1;
    if (src1.size() > 0 && src1[0].gap > 0) src1[0].gap = src1[0].gap - 1;
    req0.valid = v0; req1.valid = v1;
    if (v0) begin req0.data = src0[0].d; req0.last = src0[0].last; end
    else begin req0.data = $urandom; req0.last = 1'($urandom); end
    if (v1) begin req1.data = src1[0].d; req1.last = src1[0].last; end
    else begin req1.data = $urandom; req1.last = 1'($urandom); end
    #1;
    w = -1;
    if (!m_l && up) begin
      if (m_lock) w = (m_lock_own ? v1 : v0) ? int'(m_lock_own) : -1;
      else if (en) w = (v0 && v1) ? int'(m_ptr) : v0 ? 0 : v1 ? 1 : -1;
    end
    chk("accept0", req0.valid && req0.ready, w == 0);
    chk("accept1", req1.valid && req1.ready, w == 1);
    @(posedge local_clk);
    if (m_l) begin
      m_l = 0;
      if (up) m_err = 1;
      if (!m_outv) m_idle = IDLE[15:0];
    end else if (!up) begin
      m_err = 1; m_outv = 0; m_idle = IDLE[15:0];
    end else if (w < 0) begin
      m_outv = 0; m_idle = IDLE[31:16]; m_l = 1;
    end else begin
      if (w == 1) x = src1.pop_front(); else x = src0.pop_front();
      exp_q.push_back(x.d[31:16]);
      exp_q.push_back(x.d[15:0]);
      m_outv = 1; m_oown = w[0]; m_l = 1;
      if (x.last) begin m_lock = 0; m_ptr = ~w[0]; end
      else begin m_lock = 1; m_lock_own = w[0]; end
    end
  endtask

  task automatic do_reset();
    @(negedge local_clk);
    #2 reset_n = 0;
    src0.delete(); src1.delete(); exp_q.delete();
    model_reset();
    req0.valid = 0; req1.valid = 0;
    #1;
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", phase_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", out_owner, 0);
    repeat (2) @(posedge local_clk);
    #1 reset_n = 1;
    up = 0;
    mon_on = 1;
  endtask

  task automatic add_pkt(bit r);
    int n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      word_t x;
      x.d = $urandom;
      x.last = (i == n - 1);
      x.gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (r) src1.push_back(x); else src0.push_back(x);
    end
  endtask

  initial begin
    bit hit;
    req0.valid = 0; req0.data = '0; req0.last = 0;
    req1.valid = 0; req1.data = '0; req1.last = 0;
    do_reset();
    repeat (8) cyc();
    src0.push_back('{d: 32'hAABB_CCDD, last: 1'b1, gap: 0});
    repeat (6) cyc();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back('{d: 32'h1111_2222, last: 1'b1, gap: 0});
      src1.push_back('{d: 32'h3333_4444, last: 1'b1, gap: 0});
    end
    repeat (20) cyc();
    do_reset();
    src0.push_back('{d: 32'hA000_0001, last: 1'b0, gap: 0});
    src0.push_back('{d: 32'hA000_0002, last: 1'b0, gap: 2});
    src0.push_back('{d: 32'hA000_0003, last: 1'b1, gap: 0});
    src1.push_back('{d: 32'hB000_0001, last: 1'b1, gap: 0});
    src1.push_back('{d: 32'hB000_0002, last: 1'b1, gap: 0});
    repeat (18) cyc();
    stick = 1;
    repeat (6) cyc();
    chk("err_sticky", phase_err, 1);
    do_reset();
    src0.push_back('{d: 32'h5555_6666, last: 1'b1, gap: 0});
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc();
      hit = m_outv && m_l;
    end
    chk("mid_word_reached", hit, 1);
    do_reset();
    repeat (6) cyc();
    en_rand = 1;
    for (int k = 0; k < 8; k++) begin
      add_pkt(0); add_pkt(1);
      if ($urandom_range(0, 1) == 1) add_pkt(0);
      for (int i = 0; i < 400 && (src0.size() > 0 || src1.size() > 0); i++) cyc();
    end
    en_rand = 0; en = 1;
    for (int i = 0; i < 200 && (src0.size() > 0 || src1.size() > 0); i++) cyc();
    repeat (4) cyc();
    chk("src_drained", src0.size() + src1.size(), 0);
    chk("out_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
